// File: rtl/acc_sched.sv
`default_nettype none
// acc_sched: round-robin scheduler that streams operands from two requesters into an
// external accumulator in bounded batches, reporting each batch total with overflow/error flags.
module acc_sched #(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] din0,
  input  logic       req1,
  input  logic [3:0] din1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [3:0] acc_in,
  output logic       acc_clr,
  input  logic [4:0] acc_val,
  output logic       sum_valid,
  output logic [4:0] sum_out,
  output logic       sum_owner,
  output logic       sum_ovf,
  output logic       sum_err
);

  localparam logic [3:0] C_BURST = 4'(BURST);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN  = 3'd2,
    S_REPORT = 3'd3,
    S_CLEAR  = 3'd4
  } state_t;

  state_t     state_q;
  logic       owner_q;
  logic       last_q;
  logic       ovf_q;
  logic [4:0] shadow_q;
  logic [3:0] count_q;
  logic       gnt0_q;
  logic       gnt1_q;
  logic [3:0] acc_in_q;
  logic       acc_clr_q;
  logic       sum_valid_q;
  logic [4:0] sum_out_q;
  logic       sum_owner_q;
  logic       sum_ovf_q;
  logic       sum_err_q;

  logic       req_own_d;
  logic [3:0] din_own_d;
  logic [5:0] sum_d;
  logic [3:0] count_d;
  logic       owner_d;

  assign req_own_d = owner_q ? req1 : req0;
  assign din_own_d = owner_q ? din1 : din0;
  // One extra bit so a sum above 31 is visible before it is committed.
  assign sum_d     = {1'b0, shadow_q} + {2'b00, din_own_d};
  assign count_d   = count_q + 4'd1;
  assign owner_d   = (req0 & req1) ? ~last_q : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      ovf_q       <= 1'b0;
      shadow_q    <= '0;
      count_q     <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      acc_in_q    <= '0;
      acc_clr_q   <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_out_q   <= '0;
      sum_owner_q <= 1'b0;
      sum_ovf_q   <= 1'b0;
      sum_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          acc_in_q <= '0;
          if (req0 | req1) begin
            owner_q  <= owner_d;
            gnt0_q   <= ~owner_d;
            gnt1_q   <= owner_d;
            shadow_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          if (!req_own_d || sum_d > 6'd31) begin
            // Rejected operand is left on the bus for a later batch.
            ovf_q    <= req_own_d;
            acc_in_q <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            state_q  <= S_DRAIN;
          end else begin
            acc_in_q <= din_own_d;
            shadow_q <= sum_d[4:0];
            count_q  <= count_d;
            if (count_d == C_BURST) begin
              gnt0_q  <= 1'b0;
              gnt1_q  <= 1'b0;
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          acc_in_q <= '0;
          state_q  <= S_REPORT;
        end
        S_REPORT: begin
          sum_out_q   <= acc_val;
          sum_owner_q <= owner_q;
          sum_ovf_q   <= ovf_q;
          sum_err_q   <= (acc_val != shadow_q);
          sum_valid_q <= 1'b1;
          acc_clr_q   <= 1'b1;
          state_q     <= S_CLEAR;
        end
        S_CLEAR: begin
          sum_valid_q <= 1'b0;
          acc_clr_q   <= 1'b0;
          last_q      <= owner_q;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign acc_in    = acc_in_q;
  assign acc_clr   = acc_clr_q;
  assign sum_valid = sum_valid_q;
  assign sum_out   = sum_out_q;
  assign sum_owner = sum_owner_q;
  assign sum_ovf   = sum_ovf_q;
  assign sum_err   = sum_err_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_sched.sv
`default_nettype none
// tb_acc_sched: directed and random stimulus against a procedural batch-level reference model.
module tb_acc_sched;

  localparam int BURST = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic [3:0] din0 = '0;
  logic       req1 = 1'b0;
  logic [3:0] din1 = '0;
  logic       gnt0, gnt1, acc_clr, sum_valid, sum_owner, sum_ovf, sum_err;
  logic [3:0] acc_in;
  logic [4:0] acc_val, sum_out;

  acc_sched #(.BURST(BURST)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .din0(din0), .req1(req1), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .acc_in(acc_in), .acc_clr(acc_clr),
    .acc_val(acc_val),
    .sum_valid(sum_valid), .sum_out(sum_out), .sum_owner(sum_owner),
    .sum_ovf(sum_ovf), .sum_err(sum_err)
  );

  always #5 clk = ~clk;

  // Accumulator environment; corrupt injects a +1 error during a report.
  logic [4:0] acc_q;
  bit         corrupt = 1'b0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          acc_q <= '0;
    else if (acc_clr) acc_q <= '0;
    else              acc_q <= acc_q + {1'b0, acc_in};
  end
  assign acc_val = acc_q + {4'b0000, corrupt};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs, maintained by the model.
  logic       e_gnt0, e_gnt1, e_clr, e_valid, e_owner, e_ovf, e_err;
  logic [3:0] e_acc_in;
  logic [4:0] e_sum;
  bit         last_own;

  task automatic zero_exp();
    e_gnt0 = 0; e_gnt1 = 0; e_clr = 0; e_valid = 0; e_acc_in = '0;
    e_sum = '0; e_owner = 0; e_ovf = 0; e_err = 0;
  endtask

  task automatic step(output bit ab);
    @(posedge clk or posedge rst);
    ab = rst;
  endtask

  // One batch: wait for requests, stream operands, drain, report, clear.
  task automatic batch();
    bit ab, own, r, ovf;
    logic [3:0] d;
    int total, n;
    do begin
      step(ab);
      if (ab) return;
    end while (!(req0 || req1));
    own    = (req0 && req1) ? !last_own : req1;
    e_gnt0 = !own;
    e_gnt1 = own;
    total = 0; n = 0; ovf = 0;
    forever begin
      step(ab);
      if (ab) return;
      r = own ? req1 : req0;
      d = own ? din1 : din0;
      if (!r) begin e_acc_in = '0; break; end
      if (total + int'(d) > 31) begin ovf = 1; e_acc_in = '0; break; end
      total += int'(d);
      n++;
      e_acc_in = d;
      if (n == BURST) break;
    end
    e_gnt0 = 0; e_gnt1 = 0;
    step(ab);
    if (ab) return;
    e_acc_in = '0;
    corrupt  = ($urandom_range(0, 3) == 0);
    step(ab);
    if (ab) return;
    e_sum   = 5'(total + int'(corrupt));
    e_owner = own;
    e_ovf   = ovf;
    e_err   = corrupt;
    e_valid = 1;
    e_clr   = 1;
    step(ab);
    if (ab) return;
    e_valid  = 0;
    e_clr    = 0;
    last_own = own;
    corrupt  = 0;
  endtask

  initial begin
    zero_exp();
    last_own = 1;
    forever begin
      if (rst) begin
        zero_exp();
        last_own = 1;
        corrupt  = 0;
        while (rst) @(negedge rst);
      end
      batch();
    end
  end

  bit checking = 1'b0;
  always @(negedge clk) begin
    if (checking) begin
      chk("gnt0", 32'(gnt0), 32'(e_gnt0));
      chk("gnt1", 32'(gnt1), 32'(e_gnt1));
      chk("acc_in", 32'(acc_in), 32'(e_acc_in));
      chk("acc_clr", 32'(acc_clr), 32'(e_clr));
      chk("sum_valid", 32'(sum_valid), 32'(e_valid));
      chk("sum_out", 32'(sum_out), 32'(e_sum));
      chk("sum_owner", 32'(sum_owner), 32'(e_owner));
      chk("sum_ovf", 32'(sum_ovf), 32'(e_ovf));
      chk("sum_err", 32'(sum_err), 32'(e_err));
    end
  end

  task automatic idle_gap(input int cycles);
    @(negedge clk);
    req0 = 0; req1 = 0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pulse_rst_now();
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_acc_in", 32'(acc_in), 32'd0);
    chk("rst_acc_clr", 32'(acc_clr), 32'd0);
    chk("rst_sum_valid", 32'(sum_valid), 32'd0);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checking = 1;
    @(negedge clk);
    rst = 0;

    // Single requester, constant operand.
    req0 = 1; din0 = 4'd3;
    repeat (20) @(negedge clk);
    idle_gap(8);

    // Both requesting: alternating ownership.
    req0 = 1; din0 = 4'd1; req1 = 1; din1 = 4'd2;
    repeat (40) @(negedge clk);
    idle_gap(8);

    // Large operands force overflow termination and retry.
    req0 = 1; din0 = 4'd15;
    repeat (30) @(negedge clk);
    idle_gap(8);

    // Requester withdraws after two transfers.
    req0 = 1; din0 = 4'd5;
    repeat (3) @(negedge clk);
    req0 = 0;
    repeat (10) @(negedge clk);

    // Zero-valued operands still count toward the burst.
    req1 = 1; din1 = 4'd0;
    repeat (15) @(negedge clk);
    idle_gap(8);

    // Reset while running, with both requesting afterwards.
    req0 = 1; req1 = 1; din0 = 4'd2; din1 = 4'd7;
    repeat (17) @(negedge clk);
    pulse_rst_now();
    repeat (20) @(negedge clk);
    idle_gap(8);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) req0 = ~req0;
      if ($urandom_range(0, 7) == 0) req1 = ~req1;
      if ($urandom_range(0, 2) == 0) din0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) din1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) pulse_rst_now();
    end
    idle_gap(10);

    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/acc_sched.md
ACC_SCHED -- requirements
Module: acc_sched

Interface
REQ-001 Parameter BURST, default 4, max operands accepted per batch (range 1..15).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0  input  1  requester 0 has an operand on din0.
REQ-005 din0  input  4  requester 0 operand, unsigned.
REQ-006 req1  input  1  requester 1 has an operand on din1.
REQ-007 din1  input  4  requester 1 operand, unsigned.
REQ-008 gnt0  output  1  requester 0 owns the accumulator (registered).
REQ-009 gnt1  output  1  requester 1 owns the accumulator (registered).
REQ-010 acc_in  output  4  addend to accumulator In1 port (registered); 0 when nothing to add.
REQ-011 acc_clr  output  1  clear to accumulator (registered, one-cycle pulse).
REQ-012 acc_val  input  5  current accumulator value fed back.
REQ-013 sum_valid  output  1  one-cycle pulse; batch result valid.
REQ-014 sum_out  output  5  batch total sampled from acc_val.
REQ-015 sum_owner  output  1  requester index of the reported batch.
REQ-016 sum_ovf  output  1  batch ended because the next operand would exceed 31.
REQ-017 sum_err  output  1  acc_val disagreed with internal shadow total.

Function
REQ-018 States SHALL be IDLE, RUN, DRAIN, REPORT, CLEAR; encoding free.
REQ-019 IDLE: acc_in=0, gnt0=gnt1=0; if any req high, select owner, zero shadow and count, set gnt_owner, go RUN.
REQ-020 Arbitration SHALL be round-robin: both requesting -> the one not owning the last batch; after reset requester 0 wins.
REQ-021 Transfer SHALL occur at an edge in RUN where gnt_owner and req_owner are both high and shadow+din_owner <= 31.
REQ-022 On transfer: acc_in <= din_owner, shadow <= shadow+din_owner, count <= count+1; otherwise acc_in <= 0.
REQ-023 Shadow arithmetic SHALL be 6-bit to detect exceed-31; shadow never stores >31.
REQ-024 RUN -> DRAIN when count reaches BURST after a transfer, when req_owner is low, or when shadow+din_owner > 31 (operand rejected, ovf flag set); gnt dropped on the same edge.
REQ-025 Rejected operand SHALL NOT be consumed; requester keeps req high and it is retried in a later batch.
REQ-026 DRAIN lasts one cycle with acc_in=0 so the accumulator absorbs the last addend; -> REPORT.
REQ-027 REPORT lasts one cycle; at its exit edge: sum_out <= acc_val, sum_owner <= owner, sum_ovf <= ovf flag, sum_err <= (acc_val != shadow), sum_valid <= 1, acc_clr <= 1; -> CLEAR.
REQ-028 CLEAR lasts one cycle; at its exit edge sum_valid <= 0, acc_clr <= 0, last-owner updated; -> IDLE.
REQ-029 A batch with zero transfers (req dropped at once) SHALL still report sum_out=0, ovf=0.
REQ-030 din=0 SHALL be a valid transfer counted toward BURST.
REQ-031 sum_out/sum_owner/sum_ovf/sum_err SHALL hold their value until the next report.
REQ-032 Minimum batch turnaround: last transfer edge to next grant edge = 4 cycles.

Reset
REQ-033 rst high SHALL immediately force state IDLE, last-owner=1 (so 0 wins), shadow=0, count=0, and all outputs 0.
REQ-034 rst mid-batch SHALL abandon the batch without a report; the accumulator is cleared by the shared rst, not acc_clr.

Verification
REQ-035 req0=1, din0=3 held, req1=0 -> 4 transfers, acc_in=3 x4, sum_out=12, owner 0, ovf 0, err 0.
REQ-036 req0/req1 both high, din0=1, din1=2 -> batch owner 0 sum 4, then owner 1 sum 8, then owner 0.
REQ-037 req0=1, din0=15 -> transfers 15,15; third rejected -> sum_out=30, ovf=1; next batch begins with 15.
REQ-038 req0=1, din0=5, drop req0 after 2 transfers -> sum_out=10, ovf=0.
REQ-039 rst pulsed while in RUN -> gnt, acc_in, acc_clr, sum_valid all 0 same cycle; next grant goes to requester 0.
REQ-040 acc_val forced to shadow+1 during REPORT -> sum_err=1 with sum_valid.
